// File: rtl/udp_tx_arb.sv
// Round-robin arbiter sharing one UDP transmit engine among four frame requesters.
// Latches the winner's length/destination, issues the start pulse and guards tx_done with a watchdog.
module udp_tx_arb #(
  parameter int unsigned GAP_CYC     = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   ch_req,
  input  logic [63:0]  ch_byte_num,
  input  logic [191:0] ch_des_mac,
  input  logic [127:0] ch_des_ip,
  input  logic [31:0]  ch_data,
  output logic [3:0]   ch_rd_en,
  output logic [3:0]   ch_grant,
  output logic [3:0]   ch_done,
  output logic [3:0]   ch_err,
  output logic         tx_start_en,
  output logic [15:0]  tx_byte_num,
  output logic [47:0]  des_mac,
  output logic [31:0]  des_ip,
  output logic [7:0]   tx_data,
  input  logic         tx_req,
  input  logic         tx_done,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StGap} state_e;

  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_last_gnt, w_last_gnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]       r_grant, w_grant_nxt;
  logic [3:0]       r_done, w_done_nxt;
  logic [3:0]       r_err, w_err_nxt;
  logic [15:0]      r_len, w_len_nxt;
  logic [47:0]      r_mac, w_mac_nxt;
  logic [31:0]      r_ip, w_ip_nxt;

  logic [1:0]       w_win_idx, w_try_idx;
  logic             w_win_found;
  logic [3:0]       w_win_oh;
  logic [15:0]      w_win_len;
  logic [7:0]       w_tx_data;

  // Search starts one past the last winner, so every requester is reached within four grants.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_try_idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      w_try_idx = r_last_gnt + 2'(k);
      if (!w_win_found && ch_req[w_try_idx]) begin
        w_win_idx   = w_try_idx;
        w_win_found = 1'b1;
      end
    end
  end

  assign w_win_oh  = 4'b0001 << w_win_idx;
  assign w_win_len = ch_byte_num[{w_win_idx, 4'b0000} +: 16];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_cnt_nxt      = r_cnt;
    w_grant_nxt    = r_grant;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    w_len_nxt      = r_len;
    w_mac_nxt      = r_mac;
    w_ip_nxt       = r_ip;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (w_win_found) begin
          w_last_gnt_nxt = w_win_idx;
          w_len_nxt      = w_win_len;
          w_mac_nxt      = ch_des_mac[8'(w_win_idx) * 8'd48 +: 48];
          w_ip_nxt       = ch_des_ip[{w_win_idx, 5'b00000} +: 32];
          if (w_win_len == 16'd0) begin
            w_done_nxt  = w_win_oh;
            w_err_nxt   = w_win_oh;
            w_state_nxt = StGap;
          end else begin
            w_grant_nxt = w_win_oh;
            w_state_nxt = StStart;
          end
        end
      end
      StStart: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StWaitDone;
      end
      StWaitDone: begin
        w_cnt_nxt = w_cnt_inc;
        // tx_done wins over a coincident timeout.
        if (tx_done) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = StGap;
        end else if (w_cnt_inc == TimeoutLast) begin
          w_done_nxt  = r_grant;
          w_err_nxt   = r_grant;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = StGap;
        end
      end
      StGap: begin
        if (r_cnt == GapLast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_last_gnt <= 2'd3;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_len      <= '0;
      r_mac      <= '0;
      r_ip       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_len      <= w_len_nxt;
      r_mac      <= w_mac_nxt;
      r_ip       <= w_ip_nxt;
    end
  end

  always_comb begin
    w_tx_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_grant[i]) w_tx_data = ch_data[8*i +: 8];
    end
  end

  assign tx_data     = w_tx_data;
  assign ch_rd_en    = r_grant & {4{tx_req}};
  assign ch_grant    = r_grant;
  assign ch_done     = r_done;
  assign ch_err      = r_err;
  assign tx_start_en = (r_state == StStart);
  assign tx_byte_num = r_len;
  assign des_mac     = r_mac;
  assign des_ip      = r_ip;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_udp_tx_arb.sv
// Bench for udp_tx_arb: a frame-level model checked every cycle plus directed literal checks.
module tb_udp_tx_arb;

  localparam int GAP = 12;
  localparam int TO  = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   ch_req = '0;
  logic [63:0]  ch_byte_num = '0;
  logic [191:0] ch_des_mac = '0;
  logic [127:0] ch_des_ip = '0;
  logic [31:0]  ch_data = 32'h5D_3C_2B_A5;
  logic [3:0]   ch_rd_en, ch_grant, ch_done, ch_err;
  logic         tx_start_en, busy;
  logic [15:0]  tx_byte_num;
  logic [47:0]  des_mac;
  logic [31:0]  des_ip;
  logic [7:0]   tx_data;
  logic         tx_req = 1'b0;
  logic         tx_done = 1'b0;

  udp_tx_arb #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_byte_num(ch_byte_num),
    .ch_des_mac(ch_des_mac), .ch_des_ip(ch_des_ip), .ch_data(ch_data),
    .ch_rd_en(ch_rd_en), .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .des_mac(des_mac),
    .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  int err_cnt = 0;
  int start_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame-level view of the arbiter, tracking owner, frame age and gap remaining.
  localparam int PIdle = 0, PStart = 1, PWait = 2, PGap = 3;
  int          m_phase, m_last, m_owner, m_age, m_gap_left, m_done_ch;
  logic        m_err;
  logic [15:0] m_len;
  logic [47:0] m_mac;
  logic [31:0] m_ip;

  function automatic int pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int ch);
    return (ch < 0) ? 4'b0000 : (4'b0001 << ch);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PIdle; m_last <= 3; m_owner <= -1; m_age <= 0; m_gap_left <= 0;
      m_done_ch <= -1; m_err <= 1'b0; m_len <= '0; m_mac <= '0; m_ip <= '0;
    end else begin
      m_done_ch <= -1;
      m_err     <= 1'b0;
      case (m_phase)
        PIdle: if (ch_req != 4'b0) begin
          m_last <= pick(ch_req, m_last);
          m_len  <= ch_byte_num[16*pick(ch_req, m_last) +: 16];
          m_mac  <= ch_des_mac[48*pick(ch_req, m_last) +: 48];
          m_ip   <= ch_des_ip[32*pick(ch_req, m_last) +: 32];
          if (ch_byte_num[16*pick(ch_req, m_last) +: 16] == 16'd0) begin
            m_done_ch <= pick(ch_req, m_last); m_err <= 1'b1;
            m_phase <= PGap; m_gap_left <= GAP;
          end else begin
            m_owner <= pick(ch_req, m_last); m_phase <= PStart;
          end
        end
        PStart: begin m_phase <= PWait; m_age <= 1; end
        PWait: begin
          if (tx_done) begin
            m_done_ch <= m_owner; m_owner <= -1; m_phase <= PGap; m_gap_left <= GAP;
          end else if (m_age == TO - 1) begin
            m_done_ch <= m_owner; m_err <= 1'b1; m_owner <= -1;
            m_phase <= PGap; m_gap_left <= GAP;
          end else begin
            m_age <= m_age + 1;
          end
        end
        default: begin
          if (m_gap_left == 1) m_phase <= PIdle;
          m_gap_left <= m_gap_left - 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant", ch_grant, oh(m_owner));
      chk("rd_en", ch_rd_en, oh(m_owner) & {4{tx_req}});
      chk("tx_data", tx_data, (m_owner >= 0) ? ch_data[8*m_owner +: 8] : 8'h00);
      chk("done", ch_done, oh(m_done_ch));
      chk("err", ch_err, m_err ? oh(m_done_ch) : 4'b0000);
      chk("start", tx_start_en, m_phase == PStart);
      chk("busy", busy, m_phase != PIdle);
      chk("len", tx_byte_num, m_len);
      chk("mac", des_mac, m_mac);
      chk("ip", des_ip, m_ip);
      for (int i = 0; i < 4; i++) if (ch_done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (ch_err != 4'b0) err_cnt <= err_cnt + 1;
      if (tx_start_en) begin
        for (int i = 0; i < 4; i++) if (ch_grant[i]) start_q.push_back(i);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start();
    int n;
    step(); n = 1;
    while (!tx_start_en && n < 60) begin step(); n++; end
    chk("wait_start", tx_start_en, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  int s_cyc, d_cyc, base, d0, n;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int exp_dcnt [4] = '{2, 1, 1, 1};
  int snap [4];
  int snap_err;

  initial begin
    ch_des_mac = {48'hAA_0000_0003, 48'hAA_0000_0002, 48'hAA_0000_0001, 48'h00_11_22_33_44_66};
    ch_des_ip  = {32'h0A000004, 32'h0A000003, 32'h0A000002, 32'hC0A80166};
    ch_byte_num[15:0] = 16'd10;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", ch_grant, 4'b0);
    chk("rst_mac", des_mac, 48'h0);
    rst_n = 1'b1;
    step();

    // Single request on channel 0.
    ch_req = 4'b0001;
    step();
    chk("t1_start_lat", tx_start_en, 1'b1);
    chk("t1_len", tx_byte_num, 16'd10);
    chk("t1_mac", des_mac, 48'h00_11_22_33_44_66);
    chk("t1_ip", des_ip, 32'hC0A80166);
    step();
    tx_req = 1'b1;
    #1;
    chk("t1_rd_en", ch_rd_en, 4'b0001);
    chk("t1_data", tx_data, 8'hA5);
    step(); step();
    tx_req = 1'b0; ch_req = 4'b0000; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t1_done", ch_done, 4'b0001);
    for (int k = 0; k < 11; k++) step();
    chk("t1_gap_last", busy, 1'b1);
    step();
    chk("t1_gap_end", busy, 1'b0);
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;

    // All four requesting; engine finishes every frame.
    do_reset();
    ch_byte_num = {16'd8, 16'd7, 16'd6, 16'd5};
    base = start_q.size();
    snap = done_cnt; snap_err = err_cnt;
    ch_req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start();
      step(); tx_req = 1'b1;
      step(); tx_req = 1'b0; tx_done = 1'b1;
      step(); tx_done = 1'b0;
      if (f == 4) ch_req = 4'b0000;
    end
    wait_idle();
    chk("t2_nstarts", start_q.size() - base, 5);
    for (int f = 0; f < 5; f++)
      if (base + f < start_q.size()) chk("t2_order", start_q[base + f], exp_order[f]);
    for (int i = 0; i < 4; i++) chk("t2_done_cnt", done_cnt[i] - snap[i], exp_dcnt[i]);
    chk("t2_no_err", err_cnt - snap_err, 0);

    // Zero-length frame on channel 2 is rejected.
    ch_byte_num[47:32] = 16'd0;
    ch_req = 4'b0100;
    step();
    ch_req = 4'b0000;
    chk("t3_done", ch_done, 4'b0100);
    chk("t3_err", ch_err, 4'b0100);
    chk("t3_no_start", tx_start_en, 1'b0);
    wait_idle();

    // Watchdog on channel 1, then channel 3 is served after the gap.
    ch_byte_num[31:16] = 16'd20;
    ch_req = 4'b0010;
    wait_start();
    s_cyc = cyc;
    ch_req = 4'b1000;
    step(); n = 1;
    while (ch_done == 4'b0 && n < 70) begin step(); n++; end
    chk("t4_done", ch_done, 4'b0010);
    chk("t4_err", ch_err, 4'b0010);
    chk("t4_latency", cyc - s_cyc, TO);
    d_cyc = cyc;
    wait_start();
    chk("t4_next_grant", ch_grant, 4'b1000);
    chk("t4_gap_len", cyc - d_cyc, GAP + 1);
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0; ch_req = 4'b0000;
    wait_idle();

    // Inputs changed after grant, and a stray tx_done during the gap.
    ch_byte_num[15:0] = 16'd33;
    ch_des_ip[31:0] = 32'h0A000001;
    ch_req = 4'b0001;
    wait_start();
    ch_req = 4'b0000;
    ch_byte_num[15:0] = 16'd77;
    ch_des_ip[31:0] = 32'hFFFFFFFF;
    step(); step(); step();
    chk("t5_len_held", tx_byte_num, 16'd33);
    chk("t5_ip_held", des_ip, 32'h0A000001);
    d0 = done_cnt[0];
    tx_done = 1'b1;
    step(); tx_done = 1'b0;
    step(); step(); step();
    tx_done = 1'b1;
    step(); tx_done = 1'b0;
    wait_idle();
    chk("t5_one_done", done_cnt[0] - d0, 1);

    // Reset while waiting for tx_done.
    ch_byte_num[47:32] = 16'd9;
    ch_req = 4'b0100;
    wait_start();
    ch_req = 4'b0000;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_grant", ch_grant, 4'b0);
    chk("t6_len", tx_byte_num, 16'd0);
    chk("t6_ip", des_ip, 32'd0);
    chk("t6_done", ch_done, 4'b0);
    ch_req = 4'b1111;
    step(); step();
    rst_n = 1'b1;
    wait_start();
    chk("t6_first_grant", ch_grant, 4'b0001);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
- Round-robin scheduler that shares one UDP transmit engine between 4 frame requesters.
- Sits in the GMII TX clock domain, between user-side packet sources and the UDP top's user interface (tx_start_en, tx_data, tx_byte_num, des_mac, des_ip, tx_req, tx_done).
- Latches the winning channel's length and destination, issues the start pulse, and steers data requests and data back to that channel.
- Enforces an inter-frame gap and a tx_done watchdog.

Parameters:
- GAP_CYC, 12, idle cycles inserted after each frame completes before the next arbitration (minimum 1).
- TIMEOUT_CYC, 20'd1000000, cycles allowed from tx_start_en to tx_done before the frame is aborted.
- CNT_W, 20, width of the shared gap/watchdog counter; must hold both GAP_CYC and TIMEOUT_CYC.

Ports:
- clk  in  1  GMII TX clock.
- rst_n  in  1  asynchronous reset, active low.
- ch_req  in  4  per-channel frame request, level; held until that channel's ch_done.
- ch_byte_num  in  64  4x16 payload byte counts; channel i = [16i+15:16i].
- ch_des_mac  in  192  4x48 destination MAC addresses.
- ch_des_ip  in  128  4x32 destination IP addresses.
- ch_data  in  32  4x8 payload bytes; channel i = [8i+7:8i].
- ch_rd_en  out  4  tx_req forwarded to the granted channel only.
- ch_grant  out  4  one-hot, high while a channel owns the engine.
- ch_done  out  4  one-cycle pulse when a channel's frame ends (normal, aborted or rejected).
- ch_err  out  4  one-cycle pulse, coincident with ch_done, on abort or reject.
- tx_start_en  out  1  one-cycle start pulse to the UDP engine.
- tx_byte_num  out  16  latched payload length.
- des_mac  out  48  latched destination MAC.
- des_ip  out  32  latched destination IP.
- tx_data  out  8  ch_data of the granted channel; 8'd0 when none is granted.
- tx_req  in  1  engine data request.
- tx_done  in  1  engine frame-complete pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous assert, active low.
- Reset values:
  - all outputs 0, state IDLE;
  - round-robin pointer last_gnt = 3, so channel 0 wins first.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE: if any ch_req is high:
  - pick the first requesting channel searching last_gnt+1, last_gnt+2, ... modulo 4;
  - at that edge, register ch_grant, tx_byte_num, des_mac and des_ip from the winner's slices; set last_gnt = winner;
  - if the winner's ch_byte_num == 0: reject. Pulse ch_done and ch_err next cycle, no tx_start_en, go to GAP.
  - otherwise go to START.
- START: tx_start_en = 1 for exactly this cycle; go to WAIT_DONE and clear the counter. Latency from ch_req sampled in IDLE to tx_start_en is 1 cycle.
- WAIT_DONE:
  - counter increments each cycle;
  - on tx_done: pulse ch_done[gnt] next cycle, go to GAP;
  - if the counter reaches TIMEOUT_CYC-1 without tx_done: pulse ch_done and ch_err, go to GAP;
  - tx_done and timeout in the same cycle count as a normal completion.
- GAP:
  - ch_grant cleared on entry;
  - count GAP_CYC cycles, then return to IDLE;
  - ch_req is not sampled during GAP.
- Data steering (combinational from the registered grant):
  - ch_rd_en = ch_grant & {4{tx_req}};
  - tx_data = ch_data slice of the granted channel;
  - tx_req seen while nothing is granted is ignored.
- tx_byte_num, des_mac and des_ip hold their latched values until the next grant; changes on ch_* inputs after grant have no effect.
- Request edge cases:
  - ch_req dropped before grant: withdrawn, no response;
  - ch_req dropped after grant: ignored, the frame completes normally;
  - ch_req still high after ch_done: re-arbitrated fairly after GAP;
  - simultaneous requests: strict round robin, no starvation. With all 4 channels requesting, the grant order is 0,1,2,3,0...
- tx_done outside WAIT_DONE: ignored.
- Reset mid-frame: immediate return to IDLE, outputs cleared, no ch_done issued.

Test Plan:
- Single request: ch_req=4'b0001, ch_byte_num[15:0]=16'd10, MAC 48'h00_11_22_33_44_66, IP 192.168.1.102. Expect tx_start_en 1 cycle after the request, latched MAC/IP/len, ch_rd_en[0] follows tx_req, ch_done[0] the cycle after tx_done, then 12 idle cycles.
- All channels requesting continuously with an engine model completing every frame: grant order 0,1,2,3,0; each ch_done pulses exactly once per frame; ch_err never asserts.
- Zero length: ch_req=4'b0100 with ch_byte_num[47:32]=0. Expect no tx_start_en; ch_done[2] and ch_err[2] pulse together.
- Timeout with TIMEOUT_CYC=50 and tx_done never asserted: ch_done[1] and ch_err[1] pulse exactly 50 cycles after tx_start_en; the next requester is served after the gap.
- ch_byte_num and ch_des_ip changed mid-frame plus tx_done injected during GAP: latched outputs stay unchanged and the stray tx_done produces no extra ch_done.
- rst_n asserted low during WAIT_DONE: all outputs 0 asynchronously; after release, channel 0 wins a 4-way request.
